// File: rtl/pd_pkg.sv
// Shared constants and header type for the ping-pong block-header store.
package pd_pkg;
   localparam int HDR_BYTES    = 80;
   localparam int CHUNK1_BYTES = 64;
   localparam int DIFF_OFFSET  = 72;
   localparam int NONCE_OFFSET = 76;

   typedef logic [HDR_BYTES-1:0][7:0] hdr_t;
endpackage

// File: rtl/pd_hdr_bank.sv
// One header bank: byte write port, written-byte mask, registered full flag, mask clear.
// With PD_NONCE_INC_EN the bank can also increment its little-endian nonce field in place.
module pd_hdr_bank
   import pd_pkg::*;
#(
   parameter int NUM_BYTES = HDR_BYTES,
   parameter int SEL_W     = 7
`ifdef PD_NONCE_INC_EN
  ,parameter int NONCE_LSB = NONCE_OFFSET
`endif
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      wr_en,
   input  logic [SEL_W-1:0]          wr_sel,
   input  logic [7:0]                wr_data,
   input  logic                      clr,
`ifdef PD_NONCE_INC_EN
   input  logic                      nonce_inc,
`endif
   output logic [NUM_BYTES-1:0][7:0] data,
   output logic                      full
);

   logic [NUM_BYTES-1:0] mask_q;
   logic [NUM_BYTES-1:0] mask_nxt;

   always_comb begin
      mask_nxt = mask_q;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (wr_en && (wr_sel == SEL_W'(i))) mask_nxt[i] = 1'b1;
      end
   end

   // Clear wins over a same-cycle write so an aborted byte never lands.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data   <= '0;
         mask_q <= '0;
         full   <= 1'b0;
      end else begin
         if (clr) begin
            mask_q <= '0;
            full   <= 1'b0;
         end else begin
            mask_q <= mask_nxt;
            full   <= &mask_nxt;
         end
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_en && !clr && (wr_sel == SEL_W'(i))) data[i] <= wr_data;
         end
`ifdef PD_NONCE_INC_EN
         if (nonce_inc) data[NONCE_LSB+3:NONCE_LSB] <= data[NONCE_LSB+3:NONCE_LSB] + 32'd1;
`endif
      end
   end

endmodule

// File: rtl/pd_header_pingpong_storage.sv
// Ping-pong header store: IO side fills the shadow bank while the core reads the active bank.
// Optional macro PD_NONCE_INC_EN adds i_nonce_inc to bump the active nonce in place.
module pd_header_pingpong_storage #(
   parameter int NUM_BYTES    = pd_pkg::HDR_BYTES,
   parameter int SEL_W        = 7,
   parameter int CHUNK1_BYTES = pd_pkg::CHUNK1_BYTES,
   parameter int DIFF_OFFSET  = pd_pkg::DIFF_OFFSET,
   parameter int NONCE_OFFSET = pd_pkg::NONCE_OFFSET
) (
   input  logic                                clk,
   input  logic                                n_rst,
   input  logic                                i_data_en,
   input  logic [7:0]                          i_data,
   input  logic [SEL_W-1:0]                    i_data_sel,
   input  logic                                i_abort,
   input  logic                                i_release,
`ifdef PD_NONCE_INC_EN
   input  logic                                i_nonce_inc,
`endif
   output logic                                o_wr_ready,
   output logic                                o_drop,
   output logic                                o_hdr_valid,
   output logic [CHUNK1_BYTES*8-1:0]           chunk_1,
   output logic [(NUM_BYTES-CHUNK1_BYTES)*8-1:0] chunk_2,
   output logic [31:0]                         difficulty
);

   logic                       ptr_q;
   logic                       hdr_valid_q;
   logic                       drop_q;
   logic [1:0]                 full;
   logic [1:0]                 wr_en;
   logic [1:0]                 clr;
   logic [NUM_BYTES-1:0][7:0]  bank_data [2];
   logic [NUM_BYTES*8-1:0]     active;
   logic                       shadow_full;
   logic                       sel_ok;
   logic                       wr_ok;
   logic                       swap;

   assign shadow_full = full[~ptr_q];
   assign o_wr_ready  = !shadow_full;
   assign sel_ok      = i_data_sel < SEL_W'(NUM_BYTES);
   assign wr_ok       = i_data_en && o_wr_ready && sel_ok && !i_abort;
   assign swap        = shadow_full && (!hdr_valid_q || i_release) && !i_abort;

   // The outgoing active bank becomes the shadow on a swap, so its mask is cleared then.
   always_comb begin
      wr_en         = '0;
      clr           = '0;
      wr_en[~ptr_q] = wr_ok;
      clr[~ptr_q]   = i_abort;
      clr[ptr_q]    = swap;
   end

`ifdef PD_NONCE_INC_EN
   logic [1:0] inc;
   always_comb begin
      inc        = '0;
      inc[ptr_q] = i_nonce_inc && hdr_valid_q && !swap;
   end
`endif

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pd_hdr_bank #(
         .NUM_BYTES (NUM_BYTES),
         .SEL_W     (SEL_W)
`ifdef PD_NONCE_INC_EN
        ,.NONCE_LSB (NONCE_OFFSET)
`endif
      ) u_bank (
         .clk       (clk),
         .n_rst     (n_rst),
         .wr_en     (wr_en[b]),
         .wr_sel    (i_data_sel),
         .wr_data   (i_data),
         .clr       (clr[b]),
`ifdef PD_NONCE_INC_EN
         .nonce_inc (inc[b]),
`endif
         .data      (bank_data[b]),
         .full      (full[b])
      );
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr_q       <= 1'b0;
         hdr_valid_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         ptr_q  <= ptr_q ^ swap;
         drop_q <= i_data_en && (!o_wr_ready || !sel_ok);
         if (swap)           hdr_valid_q <= 1'b1;
         else if (i_release) hdr_valid_q <= 1'b0;
      end
   end

   assign active      = bank_data[ptr_q];
   assign o_hdr_valid = hdr_valid_q;
   assign o_drop      = drop_q;
   assign chunk_1     = active[CHUNK1_BYTES*8-1:0];
   assign chunk_2     = active[NUM_BYTES*8-1:CHUNK1_BYTES*8];
   assign difficulty  = active[DIFF_OFFSET*8 +: 32];

endmodule
